mixcolumns_serial: RTL and testbench

//  Forward AES MixColumns engine for the encrypt datapath; the inverse-direction counterpart of the decrypt path's InvMixColumns.

---
 rtl/mixcolumns_serial_pkg.sv | 26 ++
 rtl/mixcolumns_serial_col.sv | 27 ++
 rtl/mixcolumns_serial.sv | 113 +++++++++++
 tb/tb_mixcolumns_serial.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mixcolumns_serial_pkg.sv
// Shared AES MixColumns definitions: field polynomial, FSM encoding,
// xtime and column slicing helpers used by the forward and inverse paths.
package mixcolumns_serial_pkg;

  localparam logic [7:0] GF_POLY = 8'h1B;
  localparam int         NCOLS   = 4;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_e;

  function automatic logic [7:0] xt(input logic [7:0] x);
    xt = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
  endfunction

  // Column c occupies bytes s4c..s4c+3, s0 at the MSB end.
  function automatic logic [31:0] col_get(
    input logic [127:0] s,
    input int           c
  );
    col_get = s[127-32*c -: 32];
  endfunction

endpackage

// File: rtl/mixcolumns_serial_col.sv
// Combinational forward MixColumns on one 32-bit column {a,b,c,d}.
// Built from xtime only; 3x is xt(x)^x.
module mixcolumns_col
  import mixcolumns_serial_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_a, w_b, w_c, w_d;
  logic [7:0] w_a2, w_b2, w_c2, w_d2;

  assign {w_a, w_b, w_c, w_d} = i_col;

  assign w_a2 = xt(w_a);
  assign w_b2 = xt(w_b);
  assign w_c2 = xt(w_c);
  assign w_d2 = xt(w_d);

  assign o_col = {
    w_a2 ^ w_b2 ^ w_b ^ w_c ^ w_d,
    w_a ^ w_b2 ^ w_c2 ^ w_c ^ w_d,
    w_a ^ w_b ^ w_c2 ^ w_d2 ^ w_d,
    w_a2 ^ w_a ^ w_b ^ w_c ^ w_d2
  };

endmodule

// File: rtl/mixcolumns_serial.sv
// Column-serial forward AES MixColumns with valid/ready on both sides.
// COLS_PER_CYC columns are mixed per BUSY cycle in a 128-bit working reg.
module mixcolumns_serial
  import mixcolumns_serial_pkg::*;
#(
  parameter int COLS_PER_CYC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  if (COLS_PER_CYC != 1 && COLS_PER_CYC != 2
      && COLS_PER_CYC != 4) begin : g_bad_cfg
    $error("COLS_PER_CYC must be 1, 2 or 4");
  end

  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYC);

  mc_state_e    r_state, w_state_nxt;
  logic [1:0]   r_col;
  logic         r_last;
  logic         r_bypass;
  logic [127:0] r_work;

  logic [31:0]  w_col_in  [COLS_PER_CYC];
  logic [31:0]  w_col_out [COLS_PER_CYC];
  logic [127:0] w_work_mixed;
  logic [1:0]   w_col_nxt;
  logic         w_col_wrap;
  logic         w_accept;

  for (genvar j = 0; j < COLS_PER_CYC; j++) begin : g_col
    assign w_col_in[j] = col_get(r_work, int'(r_col) + j);
    mixcolumns_col u_col (
      .i_col (w_col_in[j]),
      .o_col (w_col_out[j])
    );
  end

  always_comb begin
    w_work_mixed = r_work;
    if (!r_bypass) begin
      for (int j = 0; j < COLS_PER_CYC; j++) begin
        w_work_mixed[127-32*(int'(r_col)+j) -: 32] = w_col_out[j];
      end
    end
  end

  // Step wraps mod 4; for 4 columns/cycle the step is 0, so the
  // single group is also the last one.
  assign w_col_nxt  = r_col + COL_STEP;
  assign w_col_wrap = (w_col_nxt == 2'd0);
  assign w_accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= MC_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      MC_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = MC_BUSY;
      end
      MC_BUSY: begin
        if (r_last) w_state_nxt = MC_DONE;
      end
      MC_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          w_state_nxt = in_valid ? MC_BUSY : MC_IDLE;
        end
      end
      default: w_state_nxt = MC_IDLE;
    endcase
  end

  // r_last marks the extra BUSY cycle that presents the finished state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work   <= '0;
      r_col    <= 2'd0;
      r_last   <= 1'b0;
      r_bypass <= 1'b0;
    end else if (w_accept) begin
      r_work   <= state_in;
      r_bypass <= in_bypass;
      r_col    <= 2'd0;
      r_last   <= 1'b0;
    end else if (r_state == MC_BUSY && !r_last) begin
      r_work <= w_work_mixed;
      r_col  <= w_col_nxt;
      r_last <= w_col_wrap;
    end else if (r_state == MC_BUSY) begin
      r_last <= 1'b0;
    end
  end

  assign state_out = r_work;

endmodule

// File: tb/tb_mixcolumns_serial.sv
// Directed-vector bench for mixcolumns_serial at 1, 2 and 4 columns/cycle.
// Covers latency, bypass, backpressure, streaming and async reset.
module tb_mixcolumns_serial;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_bypass = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] state_in = '0;

  logic         rdy [3];
  logic         vld [3];
  logic [127:0] so  [3];

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [127:0] din;
    logic         byp;
    logic [127:0] dout;
  } vec_t;

  vec_t tbl [4];

  mixcolumns_serial #(.COLS_PER_CYC(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy[0]),
    .state_in(state_in), .in_bypass(in_bypass),
    .out_valid(vld[0]), .out_ready(out_ready),
    .state_out(so[0])
  );

  mixcolumns_serial #(.COLS_PER_CYC(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy[1]),
    .state_in(state_in), .in_bypass(in_bypass),
    .out_valid(vld[1]), .out_ready(out_ready),
    .state_out(so[1])
  );

  mixcolumns_serial #(.COLS_PER_CYC(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy[2]),
    .state_in(state_in), .in_bypass(in_bypass),
    .out_valid(vld[2]), .out_ready(out_ready),
    .state_out(so[2])
  );

  initial forever #5 clk = ~clk;

  task automatic chk(
    input string        name,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Circulant column matrix; m holds the first row coefficients.
  function automatic logic [127:0] mixm(
    input logic [127:0] s,
    input logic [31:0]  m
  );
    logic [127:0] r;
    logic [7:0]   acc;
    logic [7:0]   a;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) begin
          a = s[127-8*(4*c+k) -: 8];
          acc ^= gmul(a, m[31-8*((k-row)&3) -: 8]);
        end
        r[127-8*(4*c+row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] fwd(
    input logic [127:0] s,
    input logic         b
  );
    return b ? s : mixm(s, 32'h02030101);
  endfunction

  function automatic logic [127:0] inv(input logic [127:0] s);
    return mixm(s, 32'h0e0b0d09);
  endfunction

  task automatic wait_out(
    input logic [127:0] exp,
    input int           lat_exp,
    input string        name
  );
    int lat;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (vld[0]) begin
        lat = k;
        break;
      end
    end
    chk({name, "_lat"}, 128'(lat), 128'(lat_exp));
    chk({name, "_data"}, so[0], exp);
  endtask

  task automatic send_main(input logic [127:0] d, input logic b);
    int t;
    t = 0;
    @(negedge clk);
    while (!rdy[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!rdy[0]) chk("send_ready", 128'(rdy[0]), 128'd1);
    state_in  = d;
    in_bypass = b;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int           lat  [3];
    int           want [3];
    logic [127:0] got  [3];
    int           t;
    want[0] = 5;
    want[1] = 3;
    want[2] = 2;
    t = 0;
    @(negedge clk);
    while (!(rdy[0] && rdy[1] && rdy[2]) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!(rdy[0] && rdy[1] && rdy[2]))
      chk("vec_ready", 128'(rdy[0] & rdy[1] & rdy[2]), 128'd1);
    state_in  = tbl[i].din;
    in_bypass = tbl[i].byp;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      lat[d] = -1;
      got[d] = '0;
    end
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        if (vld[d] && lat[d] < 0) begin
          lat[d] = k;
          got[d] = so[d];
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("vec%0d_dut%0d_data", i, d), got[d], tbl[i].dout);
      chk($sformatf("vec%0d_dut%0d_lat", i, d),
          128'(lat[d]), 128'(want[d]));
    end
  endtask

  initial begin
    vec_t q [$];
    vec_t e;
    int   sent;
    int   rcvd;
    int   cyc;
    logic fin;
    logic fout;

    tbl[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
               128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
    tbl[1] = '{128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0,
               128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff};
    tbl[2] = '{128'h00112233_44556677_8899aabb_ccddeeff, 1'b1,
               128'h00112233_44556677_8899aabb_ccddeeff};
    tbl[3] = '{128'h01000000_00000000_00000000_80000000, 1'b0,
               128'h02010103_00000000_00000000_1b80809b};

    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_in_ready%0d", d), 128'(rdy[d]), 128'd1);
      chk($sformatf("rst_out_valid%0d", d), 128'(vld[d]), 128'd0);
      chk($sformatf("rst_state_out%0d", d), so[d], 128'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(i);

    // Backpressure: hold DONE, then release with a new block.
    @(negedge clk);
    out_ready = 1'b0;
    send_main(tbl[0].din, 1'b0);
    wait_out(tbl[0].dout, 5, "bp_first");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 128'(vld[0]), 128'd1);
      chk("bp_hold_data", so[0], tbl[0].dout);
      chk("bp_in_ready", 128'(rdy[0]), 128'd0);
    end
    out_ready = 1'b1;
    state_in  = tbl[1].din;
    in_bypass = 1'b0;
    in_valid  = 1'b1;
    #1;
    chk("bp_release_ready", 128'(rdy[0]), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_taken_valid", 128'(vld[0]), 128'd0);
    chk("bp_taken_ready", 128'(rdy[0]), 128'd0);
    wait_out(tbl[1].dout, 5, "bp_next");
    @(posedge clk);

    // Streaming against the reference model.
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    while (rcvd < 100 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (sent < 100) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        state_in  = {$urandom, $urandom, $urandom, $urandom};
        in_bypass = ($urandom_range(0, 7) == 0);
      end else begin
        in_valid = 1'b0;
      end
      fin  = in_valid && rdy[0];
      fout = vld[0] && out_ready;
      if (fout) begin
        if (q.size() == 0) begin
          chk("stream_unexpected", 128'(vld[0]), 128'd0);
        end else begin
          e = q.pop_front();
          chk("stream_data", so[0], e.dout);
          if (!e.byp) chk("stream_inverse", inv(so[0]), e.din);
        end
        rcvd++;
      end
      if (fin) begin
        q.push_back('{state_in, in_bypass, fwd(state_in, in_bypass)});
        sent++;
      end
      @(posedge clk);
    end
    in_valid = 1'b0;
    chk("stream_count", 128'(rcvd), 128'd100);

    // Asynchronous reset in the middle of BUSY.
    @(posedge clk);
    send_main(tbl[0].din, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 128'(vld[0]), 128'd0);
    chk("arst_in_ready", 128'(rdy[0]), 128'd1);
    chk("arst_state_out", so[0], 128'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("arst_no_stale", 128'(vld[0]), 128'd0);
    end
    send_main(tbl[1].din, 1'b0);
    wait_out(tbl[1].dout, 5, "arst_next");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
